// File: rtl/clock_period_meter.sv
// clock_period_meter
//   Measures the period and high time of a slow asynchronous square wave,
//   counted in clk cycles. It is the inverse of a clock divider: it turns a
//   toggling input back into a cycle count.
//
//   The first detected rise only arms the block. Each later rise publishes
//   the cycles since the previous rise (period) and the cycles from that
//   rise to the following fall (high_time). A one-cycle meas_valid pulse
//   marks the update. If no rise arrives within TIMEOUT cycles, stalled is
//   raised and the block re-arms.
//
// Parameters
//   CNT_W    width of the cycle counter and of the period/high_time outputs
//   TIMEOUT  longest measurable period in clk cycles (4 .. 2^CNT_W-1)
//
// Ports
//   clk         in   system clock; the block is single-clock
//   n_rst       in   synchronous, active-low reset
//   sig_in      in   asynchronous square wave to be measured
//   enable      in   level-sensitive measurement enable
//   period      out  [CNT_W] rise-to-rise cycles of the last completed period
//   high_time   out  [CNT_W] rise-to-fall cycles of the last completed period
//   meas_valid  out  one-cycle pulse when period/high_time update
//   stalled     out  no rise seen within TIMEOUT cycles
module clock_period_meter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] hi_lat_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] high_time_r;
  logic             meas_valid_r;
  logic             stalled_r;
  logic             s1_r;
  logic             s2_r;
  logic             s3_r;
  logic             rise_s;
  logic             fall_s;

  // Edge detection on the synchronized input. Rises and falls see the same
  // two-flop latency, so the measured intervals are unbiased.
  assign rise_s = s2_r & ~s3_r;
  assign fall_s = ~s2_r & s3_r;

  // Synchronizer, counter and measurement state machine.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      // Synchronizer flops reset high so an input already high at reset
      // is not seen as a rise.
      s1_r         <= 1'b1;
      s2_r         <= 1'b1;
      s3_r         <= 1'b1;
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      hi_lat_r     <= CNT_ZERO;
      period_r     <= CNT_ZERO;
      high_time_r  <= CNT_ZERO;
      meas_valid_r <= 1'b0;
      stalled_r    <= 1'b0;
    end else begin
      s1_r         <= sig_in;
      s2_r         <= s1_r;
      s3_r         <= s2_r;
      meas_valid_r <= 1'b0;

      if (!enable) begin
        // Disable beats any edge seen this cycle; results are held.
        state_r   <= IDLE;
        cnt_r     <= CNT_ZERO;
        stalled_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            cnt_r   <= CNT_ZERO;
            state_r <= WAIT_RISE;
          end

          WAIT_RISE: begin
            // The arming rise starts the count but publishes nothing.
            if (rise_s) begin
              cnt_r   <= CNT_ONE;
              state_r <= MEASURE;
            end else begin
              cnt_r <= CNT_ZERO;
            end
          end

          MEASURE: begin
            if (fall_s) begin
              hi_lat_r <= cnt_r;
            end else begin
              hi_lat_r <= hi_lat_r;
            end

            // A rise wins over the timeout, so period == TIMEOUT is valid.
            if (rise_s) begin
              period_r     <= cnt_r;
              high_time_r  <= hi_lat_r;
              meas_valid_r <= 1'b1;
              stalled_r    <= 1'b0;
              cnt_r        <= CNT_ONE;
            end else if (cnt_r == CNT_LIMIT) begin
              stalled_r <= 1'b1;
              cnt_r     <= CNT_ZERO;
              state_r   <= WAIT_RISE;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end

          default: begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign period     = period_r;
  assign high_time  = high_time_r;
  assign meas_valid = meas_valid_r;
  assign stalled    = stalled_r;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with TIMEOUT = 16 and CNT_W = 8.
// sig_in is driven in whole clk cycles; outputs are sampled 1 time unit
// after each rising edge. Every observed meas_valid is checked against the
// expected period/high_time of the current segment, and its spacing to the
// previous pulse against the expected period.
module tb_clock_period_meter;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             sig_in;
  logic             enable;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             stalled;

  clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .sig_in     (sig_in),
    .enable     (enable),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .stalled    (stalled)
  );

  always #5 clk = ~clk;

  int   checks           = 0;
  int   failures         = 0;
  int   tick_no          = 0;
  int   valid_cnt        = 0;
  int   stall_cycles     = 0;
  int   last_valid_tick  = -1;
  int   prev_valid_tick  = -1;
  int   rise_tick        = 0;
  int   first_stall_tick = -1;
  int   last_rise        = 0;
  int   exp_p            = 0;
  int   exp_h            = 0;
  logic prev_stalled         = 1'b0;
  logic stalled_at_valid     = 1'b0;
  logic stalled_before_valid = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk cycle; sample outputs and check any measurement pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    tick_no++;
    if (meas_valid === 1'b1) begin
      valid_cnt++;
      prev_valid_tick      = last_valid_tick;
      last_valid_tick      = tick_no;
      stalled_before_valid = prev_stalled;
      stalled_at_valid     = stalled;
      check_val("valid_period", int'(period), exp_p);
      check_val("valid_high_time", int'(high_time), exp_h);
      if (prev_valid_tick >= 0)
        check_val("valid_interval", tick_no - prev_valid_tick, exp_p);
    end
    if (stalled === 1'b1) begin
      stall_cycles++;
      if (prev_stalled !== 1'b1) first_stall_tick = tick_no;
    end
    prev_stalled = stalled;
  endtask

  task automatic start_seg(input int p, input int h);
    valid_cnt       = 0;
    stall_cycles    = 0;
    last_valid_tick = -1;
    exp_p           = p;
    exp_h           = h;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      sig_in    = 1'b1;
      rise_tick = tick_no + 1;
      for (int i = 0; i < hi; i++) tick();
      sig_in = 1'b0;
      for (int i = 0; i < lo; i++) tick();
    end
  endtask

  task automatic rearm();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  initial begin
    n_rst  = 1'b0;
    sig_in = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    check_val("rst_period", int'(period), 0);
    check_val("rst_high_time", int'(high_time), 0);
    check_val("rst_meas_valid", int'(meas_valid), 0);
    check_val("rst_stalled", int'(stalled), 0);
    n_rst = 1'b1;
    tick();
    tick();

    // 1: 2 high / 2 low, five rises -> four pulses, 2 edges after each rise
    start_seg(4, 2);
    enable = 1'b1;
    tick();
    wave(2, 2, 5);
    check_val("t1_valid_count", valid_cnt, 4);
    check_val("t1_latency", last_valid_tick - rise_tick, 2);

    // 2: 3 high / 7 low
    rearm();
    start_seg(10, 3);
    wave(3, 7, 3);
    check_val("t2_valid_count", valid_cnt, 2);
    check_val("t2_stall_cycles", stall_cycles, 0);

    // 3: stall after TIMEOUT cycles, then recover on the second new rise
    rearm();
    start_seg(4, 2);
    wave(2, 2, 5);
    check_val("t3_valid_count", valid_cnt, 4);
    last_rise        = rise_tick;
    first_stall_tick = -1;
    repeat (25) tick();
    check_val("t3_stall_latency", first_stall_tick - last_rise, 2 + TIMEOUT);
    check_val("t3_stalled", int'(stalled), 1);
    check_val("t3_period_held", int'(period), 4);
    check_val("t3_high_held", int'(high_time), 2);
    start_seg(4, 2);
    wave(2, 2, 2);
    check_val("t3_restart_valids", valid_cnt, 1);
    check_val("t3_stalled_at_valid", int'(stalled_at_valid), 0);
    check_val("t3_stalled_before_valid", int'(stalled_before_valid), 1);

    // 4: period exactly TIMEOUT is valid; TIMEOUT+1 stalls
    rearm();
    start_seg(16, 8);
    wave(8, 8, 3);
    check_val("t4_exact_valids", valid_cnt, 2);
    check_val("t4_exact_stall_cycles", stall_cycles, 0);
    rearm();
    start_seg(16, 8);
    wave(9, 8, 3);
    check_val("t4_over_valids", valid_cnt, 0);
    check_val("t4_over_stalled_seen", int'(stall_cycles > 0), 1);
    check_val("t4_over_period_held", int'(period), 16);

    // 5: disable on the cycle of a rise -> no pulse, results held, re-arm
    rearm();
    start_seg(6, 3);
    wave(3, 3, 3);
    check_val("t5_valid_count", valid_cnt, 2);
    start_seg(6, 3);
    sig_in = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    sig_in = 1'b0;
    repeat (3) tick();
    check_val("t5_drop_valids", valid_cnt, 0);
    check_val("t5_period_held", int'(period), 6);
    check_val("t5_high_held", int'(high_time), 3);
    start_seg(4, 2);
    wave(2, 2, 3);
    check_val("t5_rearm_valids", valid_cnt, 2);

    // 6: reset mid-measurement with sig_in high
    rearm();
    start_seg(4, 2);
    wave(2, 2, 2);
    check_val("t6_pre_valids", valid_cnt, 1);
    sig_in = 1'b1;
    tick();
    tick();
    n_rst = 1'b0;
    tick();
    check_val("t6_rst_period", int'(period), 0);
    check_val("t6_rst_high_time", int'(high_time), 0);
    check_val("t6_rst_meas_valid", int'(meas_valid), 0);
    check_val("t6_rst_stalled", int'(stalled), 0);
    n_rst = 1'b1;
    start_seg(4, 2);
    tick();
    tick();
    sig_in = 1'b0;
    tick();
    tick();
    wave(2, 2, 2);
    check_val("t6_post_valids", valid_cnt, 1);
    check_val("t6_post_latency", last_valid_tick - rise_tick, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the period and high time of a slow, asynchronous square-wave input in system-clock cycles. It is the receive-side counterpart of the team's clock dividers: a divider turns a count into a toggling clock, and this block turns a toggling clock back into a count. Its main uses are self-checking the divided clocks on the board and timing external slow signals. Results are reported with a one-cycle valid pulse, and a stalled flag is raised when the input stops toggling.

## Interface
Parameters:
- CNT_W, 32: width of the cycle counter and of the period/high_time outputs.
- TIMEOUT, 50_000_000: longest measurable period in clk cycles. Must satisfy 4 ≤ TIMEOUT ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock; the block is single-clock.
- n_rst  in  1  reset; synchronous, active-low.
- sig_in  in  1  asynchronous square wave to be measured.
- enable  in  1  measurement enable, level-sensitive.
- period  out  CNT_W  clk cycles from one detected rise to the next, from the last completed period.
- high_time  out  CNT_W  clk cycles from a detected rise to the following detected fall, from the last completed period.
- meas_valid  out  1  one-cycle pulse when period and high_time update.
- stalled  out  1  no rise seen within TIMEOUT cycles.

## Operation
- **Synchronizer:** sig_in passes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - s1, s2 and s3 all reset to 1, so an input that is already high at reset does not produce a false rise.
  - The flops run in every state.
- **State machine:** IDLE, WAIT_RISE, MEASURE.
  - IDLE: cnt = 0. Go to WAIT_RISE when enable = 1.
  - WAIT_RISE: on rise, set cnt ← 1 and go to MEASURE. This first rise only arms the block; it produces no output.
  - MEASURE: cnt ← cnt+1 every cycle.
    - On fall: hi_lat ← cnt.
    - On rise: period ← cnt, high_time ← hi_lat, meas_valid ← 1, stalled ← 0, cnt ← 1; stay in MEASURE.
    - If cnt == TIMEOUT and there is no rise: stalled ← 1, cnt ← 0, go to WAIT_RISE.
  - In any state, enable = 0 sends the block to IDLE on the next edge. In that case cnt ← 0 and stalled ← 0.
- **Arithmetic:** all values are unsigned, CNT_W bits wide. cnt never exceeds TIMEOUT, so it cannot wrap.
- **Priorities:** n_rst beats enable = 0, which beats rise, which beats timeout.
  - A rise in the same cycle as cnt == TIMEOUT is a valid measurement with period = TIMEOUT.
  - enable falling in the same cycle as a rise gives no meas_valid.
- **Held outputs:** period and high_time keep their values across timeout, disable and re-enable. Only reset changes them other than a valid measurement.
- **Re-arming:** after reset, enable re-assertion or timeout, the first meas_valid needs two detected rises.

## Timing
- **Reset:** synchronous, applied on the clk edge where n_rst = 0. After reset:
  - period = 0, high_time = 0, meas_valid = 0, stalled = 0;
  - state = IDLE, cnt = 0, hi_lat = 0, s1 = s2 = s3 = 1.
- **Outputs:** all outputs are registered.
- **Latency:** suppose sig_in is first sampled high at clk edge k.
  - rise is asserted during the cycle after edge k+1.
  - period, high_time and meas_valid update at edge k+2.
  - Latency is identical for rises and falls, so measured values equal the true period and high time to within ±1 clk of synchronizer jitter.
- **meas_valid:** high for exactly one cycle per completed period. The consumer must take the data in that cycle; there is no backpressure.
- **stalled:** rises at the edge where cnt == TIMEOUT with no rise, i.e. TIMEOUT cycles after the last detected rise. It stays high until the next meas_valid, a disable, or a reset.
- **Minimum input:** high and low phases must each last at least 2 clk cycles to be resolved.

## Test plan
1. Reset, enable = 1, sig_in = 2 clk high / 2 clk low → first meas_valid at the second rise (+2 edges); period = 4, high_time = 2; a meas_valid pulse every 4 cycles after that.
2. sig_in = 3 high / 7 low → period = 10 and high_time = 3 on every valid; stalled = 0 throughout.
3. TIMEOUT = 16: run case 1, then hold sig_in low → stalled = 1 exactly 16 cycles after the last detected rise, with period = 4 held. Restart toggling → the first rise gives no valid; the second rise gives meas_valid, and stalled clears in the same cycle.
4. TIMEOUT = 16, sig_in period of exactly 16 clk → meas_valid with period = 16 and stalled never asserted. Period of 17 → stalled = 1 and no meas_valid.
5. Drop enable for 1 cycle mid-period → no meas_valid for that period; period/high_time hold; the next valid needs two new rises.
6. Assert n_rst = 0 for 1 cycle while sig_in = 1 mid-measurement → all outputs are 0 at the next edge; no spurious rise afterward; first meas_valid only after two full rises.
